// File: rtl/intr_flag_ctrl.sv
// Interrupt request/enable controller: synchronises INTR, sequences
// IDLE/PEND/ISR, saves and restores C/Z around the service routine.
module intr_flag_ctrl (
  input  logic CLK,
  input  logic RST,
  input  logic INTR,
  input  logic C,
  input  logic Z,
  input  logic I_SET,
  input  logic I_CLR,
  input  logic INT_ACK,
  input  logic RETIE,
  input  logic RETID,
  output logic INT_REQ,
  output logic I_FLAG,
  output logic SHAD_C,
  output logic SHAD_Z,
  output logic FLG_RESTORE,
  output logic ERR
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ISR  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   sync1_q, sync2_q, dly_q;
  logic   pend_q, pend_d;
  logic   i_flag_q, i_flag_d;
  logic   shad_c_q, shad_c_d;
  logic   shad_z_q, shad_z_d;
  logic   flg_restore_q, flg_restore_d;
  logic   err_q, err_d;

  logic   edge_det;
  logic   int_req;
  logic   ack_ok;
  logic   ret_any;
  logic   ret_ok;

  assign edge_det = sync2_q & ~dly_q;
  assign int_req  = (state_q == PEND) & i_flag_q;
  assign ack_ok   = INT_ACK & int_req;
  assign ret_any  = RETIE | RETID;
  assign ret_ok   = ret_any & (state_q == ISR);

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    i_flag_d      = i_flag_q;
    shad_c_d      = shad_c_q;
    shad_z_d      = shad_z_q;
    flg_restore_d = ret_ok;
    err_d         = err_q;

    if ((INT_ACK & ~int_req) | (ret_any & (state_q != ISR)) | (RETIE & RETID))
      err_d = 1'b1;

    // Enable precedence: accepted ack, accepted return, CLI, SEI.
    if (ack_ok)
      i_flag_d = 1'b0;
    else if (ret_ok)
      i_flag_d = RETIE & ~RETID;
    else if (I_CLR)
      i_flag_d = 1'b0;
    else if (I_SET)
      i_flag_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (edge_det)
          state_d = PEND;
      end
      PEND: begin
        if (ack_ok) begin
          state_d  = ISR;
          shad_c_d = C;
          shad_z_d = Z;
          if (edge_det)
            pend_d = 1'b1;
        end
      end
      ISR: begin
        if (ret_ok) begin
          // An edge arriving with the return is folded into the pending request.
          state_d = (pend_q | edge_det) ? PEND : IDLE;
          pend_d  = 1'b0;
        end else if (edge_det) begin
          pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      dly_q         <= 1'b0;
      pend_q        <= 1'b0;
      i_flag_q      <= 1'b0;
      shad_c_q      <= 1'b0;
      shad_z_q      <= 1'b0;
      flg_restore_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= INTR;
      sync2_q       <= sync1_q;
      dly_q         <= sync2_q;
      pend_q        <= pend_d;
      i_flag_q      <= i_flag_d;
      shad_c_q      <= shad_c_d;
      shad_z_q      <= shad_z_d;
      flg_restore_q <= flg_restore_d;
      err_q         <= err_d;
    end
  end

  assign INT_REQ     = int_req;
  assign I_FLAG      = i_flag_q;
  assign SHAD_C      = shad_c_q;
  assign SHAD_Z      = shad_z_q;
  assign FLG_RESTORE = flg_restore_q;
  assign ERR         = err_q;

endmodule

// File: tb/tb_intr_flag_ctrl.sv
// Directed bench for intr_flag_ctrl: vector table plus hand-written
// sequences; outputs packed as {INT_REQ,I_FLAG,SHAD_C,SHAD_Z,FLG_RESTORE,ERR}.
module tb_intr_flag_ctrl;

  logic CLK = 1'b0;
  logic RST, INTR, C, Z, I_SET, I_CLR, INT_ACK, RETIE, RETID;
  logic INT_REQ, I_FLAG, SHAD_C, SHAD_Z, FLG_RESTORE, ERR;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [8:0] in;   // {rst,intr,c,z,iset,iclr,ack,retie,retid}
    logic [5:0] exp;
  } vec_t;

  vec_t tbl [22];

  intr_flag_ctrl dut (
    .CLK(CLK), .RST(RST), .INTR(INTR), .C(C), .Z(Z),
    .I_SET(I_SET), .I_CLR(I_CLR), .INT_ACK(INT_ACK),
    .RETIE(RETIE), .RETID(RETID), .INT_REQ(INT_REQ), .I_FLAG(I_FLAG),
    .SHAD_C(SHAD_C), .SHAD_Z(SHAD_Z), .FLG_RESTORE(FLG_RESTORE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Apply one cycle of inputs, clock it, then compare outputs 1 ns after the edge.
  task automatic step(input logic [8:0] in, input logic [5:0] exp, input string name);
    logic [5:0] act;
    {RST, INTR, C, Z, I_SET, I_CLR, INT_ACK, RETIE, RETID} = in;
    @(posedge CLK);
    #1;
    act = {INT_REQ, I_FLAG, SHAD_C, SHAD_Z, FLG_RESTORE, ERR};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (req,ien,sc,sz,rst,err)", name, act, exp);
    end
  endtask

  initial begin
    {RST, INTR, C, Z, I_SET, I_CLR, INT_ACK, RETIE, RETID} = 9'b1_0000_0000;
    //            r i c z s l a e d        req ien sc sz fr err
    tbl[0]  = '{9'b1_0_0_0_0_0_0_0_0, 6'b0_0_0_0_0_0};  // reset
    tbl[1]  = '{9'b0_0_0_0_1_0_0_0_0, 6'b0_1_0_0_0_0};  // SEI
    tbl[2]  = '{9'b0_1_0_0_0_0_0_0_0, 6'b0_1_0_0_0_0};  // INTR at edge k
    tbl[3]  = '{9'b0_1_0_0_0_0_0_0_0, 6'b0_1_0_0_0_0};
    tbl[4]  = '{9'b0_1_0_0_0_0_0_0_0, 6'b1_1_0_0_0_0};  // INT_REQ after k+2
    tbl[5]  = '{9'b0_1_1_0_0_0_1_0_0, 6'b0_0_1_0_0_0};  // ack C=1 Z=0
    tbl[6]  = '{9'b0_0_0_0_0_0_0_0_0, 6'b0_0_1_0_0_0};
    tbl[7]  = '{9'b0_0_0_0_0_0_0_1_0, 6'b0_1_1_0_1_0};  // RETIE
    tbl[8]  = '{9'b0_0_0_0_0_0_0_0_0, 6'b0_1_1_0_0_0};  // restore strobe ends
    tbl[9]  = '{9'b0_0_0_0_0_1_0_0_0, 6'b0_0_1_0_0_0};  // CLI
    tbl[10] = '{9'b0_1_0_0_0_0_0_0_0, 6'b0_0_1_0_0_0};  // masked edge
    tbl[11] = '{9'b0_1_0_0_0_0_0_0_0, 6'b0_0_1_0_0_0};
    tbl[12] = '{9'b0_1_0_0_0_0_0_0_0, 6'b0_0_1_0_0_0};
    tbl[13] = '{9'b0_1_0_0_0_0_0_0_0, 6'b0_0_1_0_0_0};
    tbl[14] = '{9'b0_1_0_0_1_0_0_0_0, 6'b1_1_1_0_0_0};  // SEI unmasks
    tbl[15] = '{9'b0_1_0_1_0_0_1_0_0, 6'b0_0_0_1_0_0};  // ack C=0 Z=1
    tbl[16] = '{9'b0_1_0_0_0_0_0_1_0, 6'b0_1_0_1_1_0};
    tbl[17] = '{9'b0_1_0_0_0_0_0_0_0, 6'b0_1_0_1_0_0};
    tbl[18] = '{9'b0_1_1_0_0_0_1_0_0, 6'b0_1_0_1_0_1};  // ack in IDLE
    tbl[19] = '{9'b0_1_0_0_1_1_0_0_0, 6'b0_0_0_1_0_1};  // SEI+CLI
    tbl[20] = '{9'b0_1_0_0_0_0_0_0_1, 6'b0_0_0_1_0_1};  // RETID in IDLE
    tbl[21] = '{9'b1_0_0_0_0_0_0_0_0, 6'b0_0_0_0_0_0};  // reset clears ERR

    for (int i = 0; i < 22; i++)
      step(tbl[i].in, tbl[i].exp, $sformatf("vec%0d", i));

    // Nested edge during ISR, then RETID returns to PEND with enables off.
    step(9'b0_0_0_0_1_0_0_0_0, 6'b010000, "nest_sei");
    step(9'b0_1_0_0_0_0_0_0_0, 6'b010000, "nest_intr0");
    step(9'b0_1_0_0_0_0_0_0_0, 6'b010000, "nest_intr1");
    step(9'b0_1_0_0_0_0_0_0_0, 6'b110000, "nest_req");
    step(9'b0_0_1_1_0_0_1_0_0, 6'b001100, "nest_ack");
    step(9'b0_0_0_0_0_0_0_0_0, 6'b001100, "nest_isr");
    step(9'b0_1_0_0_0_0_0_0_0, 6'b001100, "nest_edge0");
    step(9'b0_1_0_0_0_0_0_0_0, 6'b001100, "nest_edge1");
    step(9'b0_0_0_0_0_0_0_0_0, 6'b001100, "nest_latched");
    step(9'b0_0_0_0_0_0_0_0_1, 6'b001110, "nest_retid");
    step(9'b0_0_0_0_0_0_0_0_0, 6'b001100, "nest_pend_masked");
    step(9'b0_0_0_0_1_0_0_0_0, 6'b111100, "nest_sei_req");

    // Reset while in ISR, with RETIE in the reset cycle too.
    step(9'b0_0_0_0_0_0_1_0_0, 6'b000000, "rst_ack");
    step(9'b1_0_0_0_0_0_0_1_0, 6'b000000, "rst_mid_isr");
    step(9'b0_0_0_0_0_0_0_1_0, 6'b000001, "rst_late_retie");
    step(9'b0_0_0_0_0_0_0_0_0, 6'b000001, "err_sticky");
    step(9'b0_0_0_0_1_0_0_0_0, 6'b010001, "rst_sei_no_req");

    // RETIE and RETID together inside ISR act as RETID and flag an error.
    step(9'b1_0_0_0_0_0_0_0_0, 6'b000000, "both_rst");
    step(9'b0_0_0_0_1_0_0_0_0, 6'b010000, "both_sei");
    step(9'b0_1_0_0_0_0_0_0_0, 6'b010000, "both_intr0");
    step(9'b0_1_0_0_0_0_0_0_0, 6'b010000, "both_intr1");
    step(9'b0_1_0_0_0_0_0_0_0, 6'b110000, "both_req");
    step(9'b0_0_1_1_0_0_1_0_0, 6'b001100, "both_ack");
    step(9'b0_0_0_0_0_0_0_1_1, 6'b001111, "both_ret");
    step(9'b0_0_0_0_0_0_0_0_0, 6'b001101, "both_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/intr_flag_ctrl.md
INTR_FLAG_CTRL -- requirements
Module: intr_flag_ctrl

Interface
REQ-001 The block SHALL provide port CLK, input, 1 bit: system clock; all state changes on its rising edge.
REQ-002 The block SHALL provide port RST, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-003 The block SHALL provide port INTR, input, 1 bit: external interrupt request, asynchronous to CLK.
REQ-004 The block SHALL provide ports C and Z, input, 1 bit each: current C_FLAG and Z_FLAG values from the flag registers.
REQ-005 The block SHALL provide ports I_SET and I_CLR, input, 1 bit each: SEI and CLI strobes from the control unit.
REQ-006 The block SHALL provide port INT_ACK, input, 1 bit: control unit is entering its interrupt cycle.
REQ-007 The block SHALL provide ports RETIE and RETID, input, 1 bit each: return-from-interrupt strobes; RETIE re-enables interrupts, RETID leaves them disabled.
REQ-008 The block SHALL provide port INT_REQ, output, 1 bit: interrupt request to the control unit.
REQ-009 The block SHALL provide port I_FLAG, output, 1 bit: interrupt-enable flag.
REQ-010 The block SHALL provide ports SHAD_C and SHAD_Z, output, 1 bit each: shadow (saved) flags.
REQ-011 The block SHALL provide port FLG_RESTORE, output, 1 bit: one-cycle strobe telling the flag registers to load SHAD_C and SHAD_Z.
REQ-012 The block SHALL provide port ERR, output, 1 bit: sticky protocol-error flag.

Function
REQ-013 The block SHALL pass INTR through a 2-flop synchronizer and a third delay flop; a rising edge is detected when sync2=1 and the delay flop=0.
- With INTR high before CLK edge k, the edge is detected in the cycle after edge k+1.
- The state or pend latch updates at edge k+2.
REQ-014 The FSM SHALL have exactly three states: IDLE, PEND and ISR.
REQ-015 In IDLE, a detected edge SHALL cause a transition to PEND.
REQ-016 INT_REQ SHALL be combinational and equal to (state==PEND) AND I_FLAG; while I_FLAG=0 the block SHALL remain in PEND.
REQ-017 In PEND, INT_ACK=1 SHALL, at the same edge, capture SHAD_C<=C and SHAD_Z<=Z, clear I_FLAG, and move the FSM to ISR.
REQ-018 INT_ACK SHALL be ignored and ERR SHALL be set whenever INT_REQ=0.
REQ-019 In ISR, a detected edge SHALL set the internal pend latch; INT_REQ SHALL stay 0.
REQ-020 In ISR, RETIE or RETID SHALL:
- set I_FLAG to 1 for RETIE, or 0 for RETID;
- drive FLG_RESTORE=1 for exactly the next cycle;
- move the FSM to PEND if the pend latch is set (clearing the latch), otherwise to IDLE.
REQ-021 RETIE or RETID outside ISR SHALL be ignored, except that ERR SHALL be set; RETIE and RETID asserted together SHALL be treated as RETID and SHALL set ERR.
REQ-022 SHAD_C and SHAD_Z SHALL change only on an accepted INT_ACK and SHALL hold stable through the FLG_RESTORE cycle.
REQ-023 I_FLAG precedence SHALL be, highest first:
- accepted INT_ACK;
- accepted RETIE/RETID;
- I_CLR;
- I_SET.
REQ-024 A detected edge in the same cycle as an accepted INT_ACK SHALL set the pend latch, so the new request is not lost.
REQ-025 Edges detected while in PEND SHALL merge with the existing request; no counting is performed.
REQ-026 ERR SHALL remain 1 until reset.

Reset
REQ-027 RST=1 SHALL, at the next CLK edge, clear the following regardless of any other input in that cycle:
- FSM to IDLE;
- synchronizer flops, delay flop and pend latch to 0;
- I_FLAG, SHAD_C, SHAD_Z, FLG_RESTORE, ERR, INT_REQ to 0.
REQ-028 Reset asserted while in ISR or PEND SHALL abandon the interrupt; no FLG_RESTORE SHALL be issued.
REQ-029 After reset, interrupts SHALL be disabled until I_SET is applied.

Verification
REQ-030 The bench SHALL cover each of the following scenarios:
- Basic service: reset, I_SET, INTR 0->1 at edge k -> INT_REQ=1 after edge k+2; INT_ACK with C=1, Z=0 -> SHAD_C=1, SHAD_Z=0, I_FLAG=0, INT_REQ=0.
- Restore: from ISR, pulse RETIE -> FLG_RESTORE=1 for exactly one cycle, I_FLAG=1, FSM to IDLE; SHAD_C, SHAD_Z unchanged.
- Masked request: I_FLAG=0, raise INTR -> INT_REQ stays 0; then I_SET -> INT_REQ=1 the following cycle.
- Nested edge: INTR pulses again during ISR, then RETID -> FSM to PEND, I_FLAG=0, INT_REQ=0; then I_SET -> INT_REQ=1.
- Errors and precedence: INT_ACK in IDLE -> ERR=1 and no other change; I_SET and I_CLR together -> I_FLAG=0.
- Reset mid-ISR: RST during ISR -> all outputs 0 next cycle, and a later RETIE produces no FLG_RESTORE and sets ERR.
